// File: rtl/fsqrt_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fsqrt_sched : round-robin scheduler sharing one two-cycle fsqrt unit among
//               NREQ issue ports, with a single tagged response channel.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module fsqrt_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          sq_s,
    input  logic [31:0]          sq_d,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2
    } state_t;

    localparam logic [IDW-1:0] c_last_idx = IDW'(NREQ - 1);

    state_t          state_q,     state_d;
    logic [31:0]     sq_s_q,      sq_s_d;
    logic [IDW-1:0]  tag_q,       tag_d;
    logic [IDW-1:0]  last_q,      last_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [31:0]     rsp_data_q,  rsp_data_d;

    logic            w_capture;
    logic            w_grant_en;
    logic            w_found;
    logic            w_hs;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic [31:0]     w_grant_data;

    // The result cycle may only retire when the response slot is free or draining.
    assign w_capture  = (state_q == ST_OP2) && (!rsp_valid_q || rsp_ready);
    assign w_grant_en = (state_q == ST_IDLE) || w_capture;
    assign w_hs       = w_grant_en && w_found;

    // Round-robin scan starting just after the last winner; explicit wrap compare
    // keeps it correct when NREQ is not a power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = last_q;
        for (int k = 0; k < NREQ; k++) begin
            if (w_idx == c_last_idx) begin
                w_idx = '0;
            end else begin
                w_idx = w_idx + IDW'(1);
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        req_ready    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_grant_data = req_data[32*i +: 32];
                req_ready[i] = w_hs;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sq_s_d      = sq_s_q;
        tag_d       = tag_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    state_d = ST_OP1;
                end
            end
            ST_OP1: begin
                state_d = ST_OP2;
            end
            ST_OP2: begin
                if (w_capture) begin
                    state_d = w_hs ? ST_OP1 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operand only changes on a handshake, so it is held through OP1/OP2
        // and parked in IDLE.
        if (w_hs) begin
            sq_s_d = w_grant_data;
            tag_d  = w_win;
            last_d = w_win;
        end

        if (w_capture) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = tag_q;
            rsp_data_d  = sq_d;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sq_s_q      <= '0;
            tag_q       <= '0;
            last_q      <= c_last_idx;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sq_s_q      <= sq_s_d;
            tag_q       <= tag_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign sq_s      = sq_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE) || rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fsqrt_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fsqrt_sched : bench for fsqrt_sched with a behavioural two-cycle fsqrt
//                  unit, directed vectors and a randomized scoreboard run.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_fsqrt_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         sq_s;
    logic [31:0]         sq_d;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic                busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fsqrt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sq_s      (sq_s),
        .sq_d      (sq_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // IEEE single sqrt, round to nearest; negatives and NaN give 0x7F800001,
    // denormals flush to zero.
    function automatic logic [31:0] fsqrt_ref(input logic [31:0] x);
        int     ex;
        longint mant, rad, res, bitv;
        if (x[30:0] == 31'd0) return x;
        if (x[31]) return 32'h7F80_0001;
        if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? x : 32'h7F80_0001;
        if (x[30:23] == 8'h00) return 32'h0;
        ex   = int'(x[30:23]) - 127;
        mant = longint'({1'b1, x[22:0]});
        if ((ex & 1) != 0) begin
            mant = mant << 1;
            ex   = ex - 1;
        end
        rad  = mant << 23;
        res  = 0;
        bitv = 64'sd1 << 48;
        while (bitv > rad) bitv = bitv >> 2;
        while (bitv != 0) begin
            if (rad >= res + bitv) begin
                rad = rad - (res + bitv);
                res = (res >> 1) + bitv;
            end else begin
                res = res >> 1;
            end
            bitv = bitv >> 2;
        end
        if (rad > res) res = res + 1;
        return {1'b0, 8'(ex / 2 + 127), res[22:0]};
    endfunction

    // Unit model: operand is sampled on the edge closing the first hold cycle,
    // result is presented during the following cycle.
    logic [31:0] sq_lat;
    always @(posedge clk) sq_lat <= sq_s;
    assign sq_d = fsqrt_ref(sq_lat);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input int i, input logic [31:0] d);
        req_valid[i]        = 1'b1;
        req_data[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rstn      = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    typedef struct {
        int          req;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t            vecs[8];
    int              gi[$], gc[$], ri[$], rc[$];
    logic [31:0]     rd[$];
    int              exp_id[$];
    logic [31:0]     exp_d[$];
    logic [NREQ-1:0] hsv;
    logic [NREQ-1:0] pend;
    logic [31:0]     pdata[NREQ];
    int              n, last_m, w, pid;
    logic            seen, prev_stall;
    logic [31:0]     prev_data, pdat;
    logic [IDW-1:0]  prev_id;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h4080_0000, 32'h4000_0000};
        vecs[1] = '{1, 32'h3F80_0000, 32'h3F80_0000};
        vecs[2] = '{2, 32'h4000_0000, 32'h3FB5_04F3};
        vecs[3] = '{3, 32'h4110_0000, 32'h4040_0000};
        vecs[4] = '{1, 32'hC080_0000, 32'h7F80_0001};
        vecs[5] = '{2, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{0, 32'h42C8_0000, 32'h4120_0000};
        vecs[7] = '{3, 32'h3E80_0000, 32'h3F00_0000};

        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        rstn      = 1'b0;
        tick();
        tick();

        // Reset values while rstn is held low.
        chk("rst_sq_s",      sq_s,      32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_rsp_data",  rsp_data,  32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        rstn = 1'b1;

        // Single request latency and busy timing.
        tick();
        rsp_ready = 1'b1;
        put_req(0, 32'h4080_0000);
        #1;
        chk("t1_ready_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("t1_busy_c1",  32'(busy),      32'h1);
        chk("t1_sq_s_c1",  sq_s,           32'h4080_0000);
        chk("t1_rspv_c1",  32'(rsp_valid), 32'h0);
        tick();
        chk("t1_rspv_c2",  32'(rsp_valid), 32'h0);
        tick();
        chk("t1_rspv_c3",  32'(rsp_valid), 32'h1);
        chk("t1_data_c3",  rsp_data,       32'h4000_0000);
        chk("t1_id_c3",    32'(rsp_id),    32'h0);
        tick();
        chk("t1_rspv_c4",  32'(rsp_valid), 32'h0);
        chk("t1_busy_c4",  32'(busy),      32'h0);
        chk("t1_sq_s_idle", sq_s,          32'h4080_0000);

        // Table of single transactions: latency, data and tag.
        foreach (vecs[v]) begin
            tick();
            rsp_ready = 1'b1;
            put_req(vecs[v].req, vecs[v].data);
            #1;
            chk($sformatf("vec%0d_grant", v), 32'(req_ready), 32'(1 << vecs[v].req));
            tick();
            req_valid = '0;
            n = 1;
            while (!rsp_valid && n < 12) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", v), 32'(n), 32'd3);
            chk($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp);
            chk($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].req));
            tick();
            chk($sformatf("vec%0d_drain", v), 32'(rsp_valid), 32'h0);
        end

        // All four at once: back-to-back grants every two cycles.
        do_reset();
        rsp_ready = 1'b1;
        tick();
        put_req(0, 32'h3F80_0000);
        put_req(1, 32'h4000_0000);
        put_req(2, 32'h4080_0000);
        put_req(3, 32'h4110_0000);
        gi.delete(); gc.delete(); ri.delete(); rc.delete(); rd.delete();
        for (int t = 0; t < 14; t++) begin
            #1;
            hsv = req_valid & req_ready;
            if (hsv != 0) begin gi.push_back(oh2idx(hsv)); gc.push_back(t); end
            if (rsp_valid) begin ri.push_back(int'(rsp_id)); rd.push_back(rsp_data); rc.push_back(t); end
            tick();
            req_valid = req_valid & ~hsv;
        end
        chk("t2_ngrant", 32'(gi.size()), 32'd4);
        chk("t2_nrsp",   32'(ri.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gi.size()) begin
                chk($sformatf("t2_gid%0d", k), 32'(gi[k]), 32'(k));
                chk($sformatf("t2_gcyc%0d", k), 32'(gc[k]), 32'(2 * k));
            end
            if (k < ri.size()) begin
                chk($sformatf("t2_rid%0d", k), 32'(ri[k]), 32'(k));
                chk($sformatf("t2_rcyc%0d", k), 32'(rc[k]), 32'(2 * k + 3));
            end
        end
        if (rd.size() == 4) begin
            chk("t2_rd0", rd[0], 32'h3F80_0000);
            chk("t2_rd1", rd[1], 32'h3FB5_04F3);
            chk("t2_rd2", rd[2], 32'h4000_0000);
            chk("t2_rd3", rd[3], 32'h4040_0000);
        end

        // Response back-pressure with two requests still pending.
        do_reset();
        tick();
        put_req(0, 32'h3F80_0000);
        put_req(1, 32'h4080_0000);
        put_req(2, 32'h4110_0000);
        ri.delete(); rd.delete();
        for (int t = 0; t < 30; t++) begin
            rsp_ready = !(t >= 3 && t < 9);
            #1;
            hsv = req_valid & req_ready;
            if (t >= 3 && t <= 8) begin
                chk($sformatf("t3_noready_c%0d", t), 32'(req_ready), 32'h0);
                chk($sformatf("t3_sq_s_c%0d", t), sq_s, 32'h4080_0000);
                chk($sformatf("t3_hold_c%0d", t), rsp_data, 32'h3F80_0000);
                chk($sformatf("t3_rspv_c%0d", t), 32'(rsp_valid), 32'h1);
            end
            if (rsp_valid && rsp_ready) begin ri.push_back(int'(rsp_id)); rd.push_back(rsp_data); end
            tick();
            req_valid = req_valid & ~hsv;
        end
        chk("t3_nrsp", 32'(ri.size()), 32'd3);
        if (ri.size() == 3) begin
            chk("t3_id0", 32'(ri[0]), 32'd0);
            chk("t3_id1", 32'(ri[1]), 32'd1);
            chk("t3_id2", 32'(ri[2]), 32'd2);
            chk("t3_d0", rd[0], 32'h3F80_0000);
            chk("t3_d1", rd[1], 32'h4000_0000);
            chk("t3_d2", rd[2], 32'h4040_0000);
        end

        // Fairness between two always-valid requesters.
        do_reset();
        rsp_ready = 1'b1;
        tick();
        put_req(0, 32'h3F80_0000);
        put_req(2, 32'h4080_0000);
        gi.delete();
        for (int t = 0; t < 60 && gi.size() < 8; t++) begin
            #1;
            hsv = req_valid & req_ready;
            if (hsv != 0) gi.push_back(oh2idx(hsv));
            tick();
        end
        req_valid = '0;
        chk("t4_ngrant", 32'(gi.size()), 32'd8);
        foreach (gi[k]) chk($sformatf("t4_g%0d", k), 32'(gi[k]), (k % 2 == 0) ? 32'd0 : 32'd2);

        // Reset asserted during the result cycle.
        do_reset();
        rsp_ready = 1'b1;
        tick();
        put_req(0, 32'h4080_0000);
        tick();
        req_valid = '0;
        tick();
        rstn = 1'b0;
        #1;
        chk("t6_rspv",  32'(rsp_valid), 32'h0);
        chk("t6_sq_s",  sq_s,           32'h0);
        chk("t6_ready", 32'(req_ready), 32'h0);
        chk("t6_busy",  32'(busy),      32'h0);
        chk("t6_rspd",  rsp_data,       32'h0);
        chk("t6_rspid", 32'(rsp_id),    32'h0);
        tick();
        tick();
        rstn = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        chk("t6_no_stale", 32'(seen), 32'h0);
        put_req(3, 32'h3F80_0000);
        put_req(0, 32'h3F80_0000);
        #1;
        chk("t6_rr_start", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 12) begin
            tick();
            n++;
        end
        chk("t6_latency", 32'(n), 32'd3);
        chk("t6_data",    rsp_data, 32'h3F80_0000);
        chk("t6_id",      32'(rsp_id), 32'h0);

        // Randomized traffic against a transaction-level scoreboard.
        do_reset();
        pend = '0;
        foreach (pdata[i]) pdata[i] = '0;
        last_m = NREQ - 1;
        exp_id.delete(); exp_d.delete();
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && cyc < 1500 && ($urandom % 4) == 0) begin
                    pend[i] = 1'b1;
                    pdata[i] = {($urandom % 8) == 0, 8'($urandom_range(1, 254)), 23'($urandom)};
                    req_data[32*i +: 32] = pdata[i];
                end
            end
            req_valid = pend;
            rsp_ready = (cyc < 1500) ? (($urandom % 4) != 0) : 1'b1;
            #1;
            hsv = req_valid & req_ready;
            if (req_ready != 0) begin
                w = rr_pick(last_m, req_valid);
                chk("rnd_grant", 32'(req_ready), (w < 0) ? 32'h0 : 32'(1 << w));
                if (w >= 0) begin
                    last_m = w;
                    exp_id.push_back(w);
                    exp_d.push_back(fsqrt_ref(pdata[w]));
                end
            end
            if (prev_stall) begin
                chk("rnd_hold_valid", 32'(rsp_valid), 32'h1);
                chk("rnd_hold_data",  rsp_data, prev_data);
                chk("rnd_hold_id",    32'(rsp_id), 32'(prev_id));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_id.size() == 0) begin
                    chk("rnd_unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    pid  = exp_id.pop_front();
                    pdat = exp_d.pop_front();
                    chk("rnd_rsp_id",   32'(rsp_id), 32'(pid));
                    chk("rnd_rsp_data", rsp_data, pdat);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_id    = rsp_id;
            tick();
            pend = pend & ~hsv;
        end
        req_valid = '0;
        chk("rnd_left_expected", 32'(exp_id.size()), 32'd0);
        chk("rnd_left_pending",  32'(pend), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
